// File: rtl/wf68k30l_div_sequencer_pkg.sv
// rtl/wf68k30l_div_sequencer_pkg.sv - shared codes, state enum and types for the divide sequencer
//
// Purpose : opcode/size codes presented to the integer divider, the sequencer
//           state encoding, and the packed writeback bundle produced by the
//           result formatter.
// Ports   : none (package).

package wf68k30l_div_sequencer_pkg;

    // Operation codes understood by the divider's OP/OP_IN inputs.
    localparam logic [6:0] OP_DIVS = 7'h2C;
    localparam logic [6:0] OP_DIVU = 7'h2D;

    // Operand size codes.
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_ISSUE  = 3'd1,
        SEQ_WAIT   = 3'd2,
        SEQ_ZERO   = 3'd3,
        SEQ_RESULT = 3'd4,
        SEQ_DRAIN  = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic        dq_en;
        logic        dr_en;
        logic [31:0] dq_data;
        logic [31:0] dr_data;
        logic [3:0]  nzvc;
        logic        trap;
    } wb_fmt_t;

    // Second instruction word as the divider expects it:
    // {0, Dq, signed, 64-bit, 7'b0, Dr}.
    function automatic logic [15:0] make_biw1(input logic [2:0] dq_idx,
                                              input logic       is_signed,
                                              input logic       is_64,
                                              input logic [2:0] dr_idx);
        return {1'b0, dq_idx, is_signed, is_64, 7'b0, dr_idx};
    endfunction

endpackage

// File: rtl/wf68k30l_div_sequencer_result_fmt.sv
// rtl/wf68k30l_div_sequencer_result_fmt.sv - combinational Dq/Dr writeback and CCR formatter
//
// Purpose : turns the captured divider result into register writebacks and
//           N,Z,V,C flags. Divide-by-zero and overflow suppress all writes.
// Ports   : is_long            - long (32-bit quotient) operation
//           dq_idx, dr_idx     - destination register numbers
//           quot, rem          - captured divider results
//           vflag              - captured divider overflow
//           divzero            - request was trapped as divide-by-zero
//           fmt                - formatted writeback bundle

module wf68k30l_div_sequencer_result_fmt
    import wf68k30l_div_sequencer_pkg::*;
(
    input  logic        is_long,
    input  logic [2:0]  dq_idx,
    input  logic [2:0]  dr_idx,
    input  logic [31:0] quot,
    input  logic [31:0] rem,
    input  logic        vflag,
    input  logic        divzero,
    output wb_fmt_t     fmt
);

    always_comb begin
        fmt = '0;
        if (divzero) begin
            fmt.trap = 1'b1;
            fmt.nzvc = 4'b0000;
        end else if (vflag) begin
            // Destination registers stay untouched on overflow; only V is reported.
            fmt.nzvc = 4'b0010;
        end else if (!is_long) begin
            // Word form packs remainder into the upper half of Dq.
            fmt.dq_en   = 1'b1;
            fmt.dq_data = {rem[15:0], quot[15:0]};
            fmt.nzvc    = {quot[15], (quot[15:0] == 16'h0000), 2'b00};
        end else begin
            // Both long forms write the remainder only when it has its own register;
            // with Dr==Dq the quotient wins.
            fmt.dq_en   = 1'b1;
            fmt.dq_data = quot;
            fmt.dr_en   = (dr_idx != dq_idx);
            fmt.dr_data = rem;
            fmt.nzvc    = {quot[31], (quot == 32'h0000_0000), 2'b00};
        end
    end

endmodule

// File: rtl/wf68k30l_div_sequencer.sv
// rtl/wf68k30l_div_sequencer.sv - DIVS/DIVU issue and writeback sequencer for the external divider
//
// Purpose : accepts one divide request, traps divide-by-zero locally, drives the
//           divider handshake with stable operands, presents formatted
//           writebacks, and drains divides flushed before completion.
// Ports   : CLK, RESETn                   - clock, async active-low reset
//           REQ_*                         - request handshake and operands
//           FLUSH                         - discard current operation
//           DIV_INIT/OP/OP_SIZE/BIW1/OP1-3 - divider command (held until DIV_RDY)
//           DIV_QUOTIENT/REMAINDER/VFLAG/RDY - divider response
//           RES_VALID/RES_READY           - result handshake
//           WB_*, CCR_*, TRAP_DIVZERO     - writeback bundle, valid with RES_VALID
//           BUSY, ERR_TIMEOUT             - status (timeout is sticky)

module wf68k30l_div_sequencer
    import wf68k30l_div_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 80,
    parameter int CNT_W          = 7
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_SIGNED,
    input  logic        REQ_LONG,
    input  logic        REQ_64,
    input  logic [2:0]  REQ_DQ_IDX,
    input  logic [2:0]  REQ_DR_IDX,
    input  logic [31:0] REQ_DIVISOR,
    input  logic [31:0] REQ_DVD_LO,
    input  logic [31:0] REQ_DVD_HI,
    input  logic        FLUSH,
    output logic        DIV_INIT,
    output logic [6:0]  DIV_OP,
    output logic [1:0]  DIV_OP_SIZE,
    output logic [15:0] DIV_BIW1,
    output logic [31:0] DIV_OP1,
    output logic [31:0] DIV_OP2,
    output logic [31:0] DIV_OP3,
    input  logic [31:0] DIV_QUOTIENT,
    input  logic [31:0] DIV_REMAINDER,
    input  logic        DIV_VFLAG,
    input  logic        DIV_RDY,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic        WB_DQ_EN,
    output logic        WB_DR_EN,
    output logic [2:0]  WB_DQ_IDX,
    output logic [2:0]  WB_DR_IDX,
    output logic [31:0] WB_DQ_DATA,
    output logic [31:0] WB_DR_DATA,
    output logic        CCR_WE,
    output logic [3:0]  CCR_NZVC,
    output logic        TRAP_DIVZERO,
    output logic        BUSY,
    output logic        ERR_TIMEOUT
);

    seq_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic             accept, capture, timeout_hit, cnt_clr, cnt_inc;
    logic             req_zero;

    // Request fields needed by the formatter.
    logic        long_q;
    logic [2:0]  dq_idx_q, dr_idx_q;
    logic        divzero_q;

    // Divider command registers, only reloaded for requests that reach the divider.
    logic [6:0]  div_op_q;
    logic [1:0]  div_size_q;
    logic [15:0] div_biw1_q;
    logic [31:0] div_op1_q, div_op2_q, div_op3_q;

    // Captured divider response.
    logic [31:0] quot_q, rem_q;
    logic        vflag_q;

    logic        err_q;
    wb_fmt_t     fmt;
    logic        in_result;

    assign req_zero = REQ_LONG ? (REQ_DIVISOR == 32'h0) : (REQ_DIVISOR[15:0] == 16'h0);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_q <= SEQ_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                // DIV_RDY here can only be a leftover from before a reset; ignored.
                if (REQ_VALID && !FLUSH) begin
                    accept  = 1'b1;
                    state_d = req_zero ? SEQ_ZERO : SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                cnt_clr = 1'b1;
                state_d = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (FLUSH) begin
                    // A flush coinciding with completion has nothing left to drain.
                    state_d = DIV_RDY ? SEQ_IDLE : SEQ_DRAIN;
                end else if (DIV_RDY) begin
                    capture = 1'b1;
                    state_d = SEQ_RESULT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    timeout_hit = 1'b1;
                    state_d     = SEQ_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SEQ_ZERO: begin
                state_d = SEQ_RESULT;
            end
            SEQ_RESULT: begin
                if (FLUSH || RES_READY) state_d = SEQ_IDLE;
            end
            SEQ_DRAIN: begin
                // The divider cannot be aborted; wait for it before allowing a new issue.
                if (DIV_RDY) state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q      <= '0;
            long_q     <= 1'b0;
            dq_idx_q   <= 3'd0;
            dr_idx_q   <= 3'd0;
            divzero_q  <= 1'b0;
            div_op_q   <= 7'd0;
            div_size_q <= 2'd0;
            div_biw1_q <= 16'd0;
            div_op1_q  <= 32'd0;
            div_op2_q  <= 32'd0;
            div_op3_q  <= 32'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            vflag_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 1'b1;

            if (accept) begin
                long_q    <= REQ_LONG;
                dq_idx_q  <= REQ_DQ_IDX;
                dr_idx_q  <= REQ_DR_IDX;
                divzero_q <= req_zero;
                if (!req_zero) begin
                    div_op_q   <= REQ_SIGNED ? OP_DIVS : OP_DIVU;
                    div_size_q <= REQ_LONG ? SZ_LONG : SZ_WORD;
                    div_biw1_q <= make_biw1(REQ_DQ_IDX, REQ_SIGNED,
                                            REQ_LONG && REQ_64, REQ_DR_IDX);
                    div_op1_q  <= REQ_DIVISOR;
                    div_op2_q  <= REQ_DVD_LO;
                    div_op3_q  <= REQ_DVD_HI;
                end
            end

            if (capture) begin
                quot_q  <= DIV_QUOTIENT;
                rem_q   <= DIV_REMAINDER;
                vflag_q <= DIV_VFLAG;
            end

            if (timeout_hit) err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result formatting and outputs
    // ------------------------------------------------------------------
    wf68k30l_div_sequencer_result_fmt u_fmt (
        .is_long (long_q),
        .dq_idx  (dq_idx_q),
        .dr_idx  (dr_idx_q),
        .quot    (quot_q),
        .rem     (rem_q),
        .vflag   (vflag_q),
        .divzero (divzero_q),
        .fmt     (fmt)
    );

    assign in_result    = (state_q == SEQ_RESULT);

    assign REQ_READY    = (state_q == SEQ_IDLE) && !FLUSH;
    assign DIV_INIT     = (state_q == SEQ_ISSUE);
    assign DIV_OP       = div_op_q;
    assign DIV_OP_SIZE  = div_size_q;
    assign DIV_BIW1     = div_biw1_q;
    assign DIV_OP1      = div_op1_q;
    assign DIV_OP2      = div_op2_q;
    assign DIV_OP3      = div_op3_q;

    assign RES_VALID    = in_result;
    assign WB_DQ_EN     = in_result && fmt.dq_en;
    assign WB_DR_EN     = in_result && fmt.dr_en;
    assign WB_DQ_IDX    = in_result ? dq_idx_q    : 3'd0;
    assign WB_DR_IDX    = in_result ? dr_idx_q    : 3'd0;
    assign WB_DQ_DATA   = in_result ? fmt.dq_data : 32'd0;
    assign WB_DR_DATA   = in_result ? fmt.dr_data : 32'd0;
    assign CCR_WE       = in_result;
    assign CCR_NZVC     = in_result ? fmt.nzvc    : 4'd0;
    assign TRAP_DIVZERO = in_result && fmt.trap;

    assign BUSY         = (state_q != SEQ_IDLE);
    assign ERR_TIMEOUT  = err_q;

endmodule

// File: tb/tb_wf68k30l_div_sequencer.sv
// tb/tb_wf68k30l_div_sequencer.sv - scoreboard bench for the divide sequencer

module tb_wf68k30l_div_sequencer;
    import wf68k30l_div_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        REQ_VALID, REQ_READY, REQ_SIGNED, REQ_LONG, REQ_64;
    logic [2:0]  REQ_DQ_IDX, REQ_DR_IDX;
    logic [31:0] REQ_DIVISOR, REQ_DVD_LO, REQ_DVD_HI;
    logic        FLUSH;
    logic        DIV_INIT;
    logic [6:0]  DIV_OP;
    logic [1:0]  DIV_OP_SIZE;
    logic [15:0] DIV_BIW1;
    logic [31:0] DIV_OP1, DIV_OP2, DIV_OP3;
    logic [31:0] DIV_QUOTIENT, DIV_REMAINDER;
    logic        DIV_VFLAG, DIV_RDY;
    logic        RES_VALID, RES_READY;
    logic        WB_DQ_EN, WB_DR_EN;
    logic [2:0]  WB_DQ_IDX, WB_DR_IDX;
    logic [31:0] WB_DQ_DATA, WB_DR_DATA;
    logic        CCR_WE;
    logic [3:0]  CCR_NZVC;
    logic        TRAP_DIVZERO, BUSY, ERR_TIMEOUT;

    always #5 CLK = ~CLK;

    wf68k30l_div_sequencer #(.TIMEOUT_CYCLES(80), .CNT_W(7)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SIGNED(REQ_SIGNED),
        .REQ_LONG(REQ_LONG), .REQ_64(REQ_64), .REQ_DQ_IDX(REQ_DQ_IDX),
        .REQ_DR_IDX(REQ_DR_IDX), .REQ_DIVISOR(REQ_DIVISOR), .REQ_DVD_LO(REQ_DVD_LO),
        .REQ_DVD_HI(REQ_DVD_HI), .FLUSH(FLUSH),
        .DIV_INIT(DIV_INIT), .DIV_OP(DIV_OP), .DIV_OP_SIZE(DIV_OP_SIZE),
        .DIV_BIW1(DIV_BIW1), .DIV_OP1(DIV_OP1), .DIV_OP2(DIV_OP2), .DIV_OP3(DIV_OP3),
        .DIV_QUOTIENT(DIV_QUOTIENT), .DIV_REMAINDER(DIV_REMAINDER),
        .DIV_VFLAG(DIV_VFLAG), .DIV_RDY(DIV_RDY),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .WB_DQ_EN(WB_DQ_EN), .WB_DR_EN(WB_DR_EN), .WB_DQ_IDX(WB_DQ_IDX),
        .WB_DR_IDX(WB_DR_IDX), .WB_DQ_DATA(WB_DQ_DATA), .WB_DR_DATA(WB_DR_DATA),
        .CCR_WE(CCR_WE), .CCR_NZVC(CCR_NZVC), .TRAP_DIVZERO(TRAP_DIVZERO),
        .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT)
    );

    typedef struct {
        logic        dq_en, dr_en;
        logic [2:0]  dq_idx, dr_idx;
        logic [31:0] dq_data, dr_data;
        logic [3:0]  nzvc;
        logic        trap;
        int          hold;
    } exp_res_t;

    typedef struct {
        logic [6:0]  op;
        logic [1:0]  sz;
        logic [15:0] biw1;
        logic [31:0] op1, op2, op3, quot, rem;
        logic        v;
        int          lat;
        logic        no_rdy;
    } exp_div_t;

    exp_res_t sb[$];
    exp_div_t dq[$];
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_res(input logic dq_en, input logic dr_en, input logic [2:0] dqi,
                           input logic [2:0] dri, input logic [31:0] dqd, input logic [31:0] drd,
                           input logic [3:0] nzvc, input logic trap, input int hold);
        exp_res_t e;
        e.dq_en = dq_en; e.dr_en = dr_en; e.dq_idx = dqi; e.dr_idx = dri;
        e.dq_data = dqd; e.dr_data = drd; e.nzvc = nzvc; e.trap = trap; e.hold = hold;
        sb.push_back(e);
    endtask

    task automatic exp_div(input logic [6:0] op, input logic [1:0] sz, input logic [15:0] biw1,
                           input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] op3,
                           input logic [31:0] quot, input logic [31:0] rem, input logic v,
                           input int lat, input logic no_rdy);
        exp_div_t d;
        d.op = op; d.sz = sz; d.biw1 = biw1; d.op1 = op1; d.op2 = op2; d.op3 = op3;
        d.quot = quot; d.rem = rem; d.v = v; d.lat = lat; d.no_rdy = no_rdy;
        dq.push_back(d);
    endtask

    // Divider model: checks the command at INIT, checks it stays held, then
    // returns the pre-computed response after the vector's latency.
    initial begin : divider_model
        exp_div_t d;
        logic held, aborted;
        DIV_RDY = 1'b0; DIV_QUOTIENT = '0; DIV_REMAINDER = '0; DIV_VFLAG = 1'b0;
        forever begin
            @(negedge CLK);
            if (DIV_INIT && RESETn) begin
                if (dq.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL div_init_unexpected: got DIV_INIT=1 expected 0");
                end else begin
                    d = dq.pop_front();
                    check("div_op", 32'(DIV_OP), 32'(d.op));
                    check("div_op_size", 32'(DIV_OP_SIZE), 32'(d.sz));
                    check("div_biw1", 32'(DIV_BIW1), 32'(d.biw1));
                    check("div_op1", DIV_OP1, d.op1);
                    check("div_op2", DIV_OP2, d.op2);
                    check("div_op3", DIV_OP3, d.op3);
                    if (!d.no_rdy) begin
                        held = 1'b1; aborted = 1'b0;
                        for (int i = 0; i < d.lat; i++) begin
                            @(negedge CLK);
                            if (!RESETn) aborted = 1'b1;
                            if (!aborted && (DIV_INIT || DIV_OP !== d.op || DIV_OP_SIZE !== d.sz ||
                                DIV_BIW1 !== d.biw1 || DIV_OP1 !== d.op1 ||
                                DIV_OP2 !== d.op2 || DIV_OP3 !== d.op3))
                                held = 1'b0;
                        end
                        DIV_QUOTIENT = d.quot; DIV_REMAINDER = d.rem; DIV_VFLAG = d.v;
                        DIV_RDY = 1'b1;
                        @(negedge CLK);
                        DIV_RDY = 1'b0;
                        if (!aborted) check("div_cmd_held", 32'(held), 32'd1);
                    end
                end
            end
        end
    end

    // Result monitor: pops the scoreboard whenever a result is presented.
    initial begin : res_monitor
        exp_res_t e;
        logic [71:0] snap;
        logic stable;
        RES_READY = 1'b0;
        forever begin
            @(negedge CLK);
            if (RES_VALID && RESETn) begin
                if (sb.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL res_unexpected: got RES_VALID=1 expected 0");
                end else begin
                    e = sb.pop_front();
                    check("wb_dq_en", 32'(WB_DQ_EN), 32'(e.dq_en));
                    check("wb_dr_en", 32'(WB_DR_EN), 32'(e.dr_en));
                    if (e.dq_en) begin
                        check("wb_dq_idx", 32'(WB_DQ_IDX), 32'(e.dq_idx));
                        check("wb_dq_data", WB_DQ_DATA, e.dq_data);
                    end
                    if (e.dr_en) begin
                        check("wb_dr_idx", 32'(WB_DR_IDX), 32'(e.dr_idx));
                        check("wb_dr_data", WB_DR_DATA, e.dr_data);
                    end
                    check("ccr_we", 32'(CCR_WE), 32'd1);
                    check("ccr_nzvc", 32'(CCR_NZVC), 32'(e.nzvc));
                    check("trap_divzero", 32'(TRAP_DIVZERO), 32'(e.trap));
                    snap = {WB_DQ_DATA, WB_DR_DATA, CCR_NZVC, WB_DQ_EN, WB_DR_EN, TRAP_DIVZERO, RES_VALID};
                    stable = 1'b1;
                    for (int i = 0; i < e.hold; i++) begin
                        @(negedge CLK);
                        if ({WB_DQ_DATA, WB_DR_DATA, CCR_NZVC, WB_DQ_EN, WB_DR_EN,
                             TRAP_DIVZERO, RES_VALID} !== snap) stable = 1'b0;
                    end
                    if (e.hold > 0) check("res_stable_while_stalled", 32'(stable), 32'd1);
                end
                RES_READY = 1'b1;
                @(negedge CLK);
                RES_READY = 1'b0;
            end
        end
    end

    task automatic send(input logic sgn, input logic lng, input logic is64, input logic [2:0] dqi,
                        input logic [2:0] dri, input logic [31:0] dvs, input logic [31:0] lo,
                        input logic [31:0] hi);
        int n = 0;
        @(negedge CLK);
        while (!REQ_READY && n < 200) begin @(negedge CLK); n++; end
        if (!REQ_READY) begin
            vectors++; errors++;
            $display("FAIL req_ready_wait: got REQ_READY=0 expected 1");
        end
        REQ_SIGNED = sgn; REQ_LONG = lng; REQ_64 = is64; REQ_DQ_IDX = dqi; REQ_DR_IDX = dri;
        REQ_DIVISOR = dvs; REQ_DVD_LO = lo; REQ_DVD_HI = hi; REQ_VALID = 1'b1;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((BUSY || sb.size() != 0 || RES_READY) && n < 400) begin @(negedge CLK); n++; end
        check(name, 32'(BUSY || sb.size() != 0), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_init();
        int n = 0;
        @(negedge CLK);
        while (!DIV_INIT && n < 20) begin @(negedge CLK); n++; end
        check("div_init_seen", 32'(DIV_INIT), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int rr, busy_cycles;
        logic early_err;
        RESETn = 1'b0; FLUSH = 1'b0; REQ_VALID = 1'b0; REQ_SIGNED = 1'b0; REQ_LONG = 1'b0;
        REQ_64 = 1'b0; REQ_DQ_IDX = '0; REQ_DR_IDX = '0; REQ_DIVISOR = '0;
        REQ_DVD_LO = '0; REQ_DVD_HI = '0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_div_init", 32'(DIV_INIT), 32'd0);
        check("rst_div_op", {DIV_OP, DIV_OP_SIZE, DIV_BIW1}, 32'd0);
        check("rst_div_op1", DIV_OP1 | DIV_OP2 | DIV_OP3, 32'd0);
        check("rst_res", {RES_VALID, WB_DQ_EN, WB_DR_EN, CCR_WE, TRAP_DIVZERO, ERR_TIMEOUT}, 32'd0);
        check("rst_wb_data", WB_DQ_DATA | WB_DR_DATA, 32'd0);
        RESETn = 1'b1;
        @(negedge CLK);
        check("idle_req_ready", 32'(REQ_READY), 32'd1);

        // DIVU.W 100/7: quotient 14, remainder 2; REQ_64 must be ignored for word size.
        exp_div(OP_DIVU, SZ_WORD, 16'h3005, 32'd7, 32'd100, 32'd0, 32'd14, 32'd2, 1'b0, 5, 1'b0);
        exp_res(1, 0, 3'd3, 3'd5, 32'h0002_000E, 32'd0, 4'b0000, 0, 0);
        send(0, 0, 1, 3'd3, 3'd5, 32'd7, 32'd100, 32'd0);
        wait_idle("idle_after_divu_w");

        // DIVS.L 64-bit: -100/10 = -10 rem 0, result held off by RES_READY for 5 cycles.
        exp_div(OP_DIVS, SZ_LONG, 16'h0C01, 32'd10, 32'hFFFF_FF9C, 32'hFFFF_FFFF,
                32'hFFFF_FFF6, 32'd0, 1'b0, 8, 1'b0);
        exp_res(1, 1, 3'd0, 3'd1, 32'hFFFF_FFF6, 32'd0, 4'b1000, 0, 5);
        send(1, 1, 1, 3'd0, 3'd1, 32'd10, 32'hFFFF_FF9C, 32'hFFFF_FFFF);
        wait_idle("idle_after_divs_l64");

        // Word divisor 0x00010000 is zero in its low half: trap, no divider activity.
        exp_res(0, 0, 3'd2, 3'd3, 32'd0, 32'd0, 4'b0000, 1, 0);
        send(0, 0, 0, 3'd2, 3'd3, 32'h0001_0000, 32'd5, 32'd0);
        wait_idle("idle_after_zero");

        // DIVU.W 0x00100000/1 overflows 16 bits.
        exp_div(OP_DIVU, SZ_WORD, 16'h2002, 32'd1, 32'h0010_0000, 32'd0,
                32'h0010_0000, 32'd0, 1'b1, 6, 1'b0);
        exp_res(0, 0, 3'd2, 3'd2, 32'd0, 32'd0, 4'b0010, 0, 0);
        send(0, 0, 0, 3'd2, 3'd2, 32'd1, 32'h0010_0000, 32'd0);
        wait_idle("idle_after_overflow");

        // DIVS.W 5/-1 = -5 (0xFFFB), remainder 0: N set from bit 15.
        exp_div(OP_DIVS, SZ_WORD, 16'h6801, 32'h0000_FFFF, 32'd5, 32'd0,
                32'hFFFF_FFFB, 32'd0, 1'b0, 4, 1'b0);
        exp_res(1, 0, 3'd6, 3'd1, 32'h0000_FFFB, 32'd0, 4'b1000, 0, 0);
        send(1, 0, 0, 3'd6, 3'd1, 32'h0000_FFFF, 32'd5, 32'd0);
        wait_idle("idle_after_divs_w");

        // Flush two cycles into the divide: drain until DIV_RDY, no result.
        exp_div(OP_DIVU, SZ_LONG, 16'h1001, 32'd3, 32'd9, 32'd0, 32'd3, 32'd0, 1'b0, 12, 1'b0);
        send(0, 1, 0, 3'd1, 3'd1, 32'd3, 32'd9, 32'd0);
        wait_init();
        repeat (2) @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        rr = 0;
        for (int i = 0; i < 50; i++) begin
            if (DIV_RDY) break;
            if (REQ_READY || !BUSY) rr++;
            @(negedge CLK);
        end
        check("drain_saw_div_rdy", 32'(DIV_RDY), 32'd1);
        check("drain_req_ready_low", 32'(rr), 32'd0);
        @(negedge CLK);
        check("drain_exit_req_ready", 32'(REQ_READY), 32'd1);

        // DIVU.L 0x100/0x10 with Dr==Dq: only Dq written.
        exp_div(OP_DIVU, SZ_LONG, 16'h4004, 32'h10, 32'h100, 32'd0, 32'h10, 32'd0, 1'b0, 7, 1'b0);
        exp_res(1, 0, 3'd4, 3'd4, 32'h10, 32'd0, 4'b0000, 0, 0);
        send(0, 1, 0, 3'd4, 3'd4, 32'h10, 32'h100, 32'd0);
        wait_idle("idle_after_flush_next");

        // DIVS.L 32-bit 0x1234/0x10000 (nonzero as long): quotient 0 -> Z, remainder to Dr.
        exp_div(OP_DIVS, SZ_LONG, 16'h6807, 32'h0001_0000, 32'h0000_1234, 32'd0,
                32'd0, 32'h0000_1234, 1'b0, 5, 1'b0);
        exp_res(1, 1, 3'd6, 3'd7, 32'd0, 32'h0000_1234, 4'b0100, 0, 0);
        send(1, 1, 0, 3'd6, 3'd7, 32'h0001_0000, 32'h0000_1234, 32'd0);
        wait_idle("idle_after_divs_l32");

        // FLUSH in IDLE blocks acceptance.
        @(negedge CLK);
        FLUSH = 1'b1; REQ_VALID = 1'b1; REQ_LONG = 1'b0; REQ_DIVISOR = 32'd3;
        #1 check("flush_idle_req_ready", 32'(REQ_READY), 32'd0);
        @(posedge CLK);
        #1 check("flush_idle_not_accepted", 32'(BUSY), 32'd0);
        FLUSH = 1'b0; REQ_VALID = 1'b0;

        // Divider never answers: ISSUE plus 80-81 WAIT cycles, then sticky timeout.
        exp_div(OP_DIVU, SZ_WORD, 16'h0000, 32'd3, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, 0, 1'b1);
        send(0, 0, 0, 3'd0, 3'd0, 32'd3, 32'd9, 32'd0);
        busy_cycles = 0; early_err = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!BUSY) break;
            if (ERR_TIMEOUT) early_err = 1'b1;
            busy_cycles++;
        end
        check("timeout_not_early", 32'(early_err), 32'd0);
        check("timeout_busy_in_range", 32'(busy_cycles >= 81 && busy_cycles <= 82), 32'd1);
        check("timeout_sticky", 32'(ERR_TIMEOUT), 32'd1);
        repeat (3) @(negedge CLK);
        check("timeout_still_set", 32'(ERR_TIMEOUT), 32'd1);

        // Reset mid-divide: stale DIV_RDY afterwards must be ignored.
        exp_div(OP_DIVU, SZ_WORD, 16'h0000, 32'd5, 32'd10, 32'd0, 32'd2, 32'd0, 1'b0, 20, 1'b0);
        send(0, 0, 0, 3'd0, 3'd0, 32'd5, 32'd10, 32'd0);
        wait_init();
        repeat (3) @(negedge CLK);
        RESETn = 1'b0;
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        repeat (25) @(negedge CLK);
        check("reset_mid_busy", 32'(BUSY), 32'd0);
        check("reset_clears_timeout", 32'(ERR_TIMEOUT), 32'd0);
        check("reset_mid_req_ready", 32'(REQ_READY), 32'd1);
        check("scoreboard_empty", 32'(sb.size() + dq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wf68k30l_div_sequencer.md
Name: wf68k30l_div_sequencer

Overview:
Issue/writeback controller for the integer divider in the WF68K30L execution unit. It accepts one DIVS/DIVU request at a time from the execution pipeline and detects divide-by-zero locally, without starting the divider. It drives the divider handshake and holds the operands stable until the divider reports ready. It then formats quotient/remainder into Dq/Dr writebacks plus CCR flags, and it drains a divide that was flushed before completion.

Parameters:
TIMEOUT_CYCLES, 80, max cycles in WAIT before ERR_TIMEOUT asserts (must exceed 64-bit divide length + 4)
CNT_W, 7, width of cycle counter

Ports:
CLK  in  1  clock
RESETn  in  1  reset, asynchronous active-low
REQ_VALID  in  1  request present
REQ_READY  out  1  sequencer accepts request
REQ_SIGNED  in  1  1=DIVS, 0=DIVU
REQ_LONG  in  1  1=long, 0=word
REQ_64  in  1  64-bit dividend (DIVx.L Dr:Dq form), ignored if !REQ_LONG
REQ_DQ_IDX  in  3  quotient register
REQ_DR_IDX  in  3  remainder register
REQ_DIVISOR  in  32  source operand
REQ_DVD_LO  in  32  Dq contents
REQ_DVD_HI  in  32  Dr contents (64-bit high half)
FLUSH  in  1  discard current operation
DIV_INIT  out  1  one-cycle start pulse to divider
DIV_OP  out  7  DIVS/DIVU package code
DIV_OP_SIZE  out  2  WORD/LONG package code
DIV_BIW1  out  16  {1'b0, Dq idx, signed, 64-bit, 7'b0, Dr idx}
DIV_OP1/DIV_OP2/DIV_OP3  out  32 each  divisor / dividend low / dividend high
DIV_QUOTIENT, DIV_REMAINDER  in  32 each  divider results
DIV_VFLAG  in  1  divider overflow
DIV_RDY  in  1  divider done pulse
RES_VALID  out  1  result present
RES_READY  in  1  consumer accepts result
WB_DQ_EN, WB_DR_EN  out  1 each  register write enables
WB_DQ_IDX, WB_DR_IDX  out  3 each
WB_DQ_DATA, WB_DR_DATA  out  32 each
CCR_WE  out  1  update N,Z,V,C
CCR_NZVC  out  4
TRAP_DIVZERO  out  1  zero-divide exception, valid with RES_VALID
BUSY  out  1  state != IDLE
ERR_TIMEOUT  out  1  sticky until reset

Behaviour:
- Reset: state IDLE; all outputs 0 (including DIV_OP*, WB_*, ERR_TIMEOUT). REQ_READY=1 only in IDLE with FLUSH=0.
- Accept: REQ_VALID&&REQ_READY latches all REQ_* fields. Zero test: REQ_LONG ? divisor==0 : divisor[15:0]==0.
- States:
  - IDLE -> ZERO on accept with zero divisor.
  - IDLE -> ISSUE on accept with nonzero divisor.
  - ISSUE: DIV_INIT=1 for exactly one cycle -> WAIT; counter cleared.
  - WAIT: counter++; on DIV_RDY capture results -> RESULT. FLUSH -> DRAIN. Counter==TIMEOUT_CYCLES -> set ERR_TIMEOUT, -> IDLE.
  - ZERO: one cycle -> RESULT with TRAP_DIVZERO=1, no divider activity.
  - RESULT: RES_VALID=1 with all WB_*/CCR_*/TRAP outputs stable; exit to IDLE on RES_READY. FLUSH -> IDLE, result dropped.
  - DRAIN: wait for DIV_RDY, discard, -> IDLE. The divider cannot be aborted, so no new ISSUE is allowed before its DIV_RDY.
- DIV_OP/DIV_OP_SIZE/DIV_BIW1/DIV_OP1-3 are held constant from ISSUE through the DIV_RDY cycle. The divider samples OP_IN at INIT and OP one cycle later.
- Writeback formatting when RESULT is reached with DIV_VFLAG=0 and no trap:
  - Word: WB_DQ_DATA={rem[15:0],quot[15:0]}, WB_DQ_EN=1, WB_DR_EN=0.
  - Long, 32-bit dividend: WB_DQ_DATA=quot. WB_DR_EN=1 and WB_DR_DATA=rem only if Dr!=Dq.
  - Long, 64-bit dividend: Dq=quot, Dr=rem. If Dr==Dq, only Dq is written.
  - CCR: N=quot msb of operand size, Z=(quot of size==0), V=0, C=0, CCR_WE=1.
- Overflow (DIV_VFLAG=1): WB enables 0, CCR_WE=1, NZVC=4'b0010.
- Divide-by-zero: WB enables 0, TRAP_DIVZERO=1, CCR_WE=1, NZVC=4'b0000.
- Simultaneous events: FLUSH together with DIV_RDY in WAIT -> IDLE, result dropped. FLUSH in IDLE blocks acceptance that cycle.
- Reset mid-operation returns to IDLE. The unreset divider may still emit a stale DIV_RDY, which IDLE ignores.

Decomposition:
- Shared package supplies DIVS/DIVU opcode codes, WORD/LONG size codes, and the sequencer state enum (SEQ_IDLE, SEQ_ISSUE, SEQ_WAIT, SEQ_ZERO, SEQ_RESULT, SEQ_DRAIN).
- Sub-module div_result_fmt (combinational writeback/CCR formatter) is natural.
- The divider is instantiated by the parent, not inside this block.

Test Plan:
- DIVU.W divisor=7, Dq=100 -> DIV_INIT once; RESULT WB_DQ_DATA=0x0002000E, NZVC=0000.
- DIVS.L 64-bit, Dr:Dq=0xFFFFFFFF_FFFFFF9C, divisor=10, Dq=0, Dr=1 -> Dq=0xFFFFFFF6, Dr=0, both enables, NZVC=1000.
- Divisor=0x00010000 word, Dq=5 -> ZERO path, DIV_INIT never pulses, TRAP_DIVZERO=1, no writeback.
- DIVU.W divisor=1, Dq=0x00100000 -> overflow, NZVC=0010, WB enables 0.
- FLUSH two cycles after ISSUE -> DRAIN, REQ_READY stays 0 until DIV_RDY, no RES_VALID. The next request then completes correctly.
- RES_READY held low 5 cycles -> RES_VALID and data stable. DIV_RDY never returned -> ERR_TIMEOUT after 80 WAIT cycles.
